// File: rtl/stream_demux_router.sv
// rtl/stream_demux_router.sv - packet-aware 1-to-N stream router with one registered output stage
// Routes each packet to m_*[id] (id taken from the header beat); out-of-range packets are dropped and counted.
module stream_demux_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_W   = 16
) (
  input  logic                                      clk_i,
  input  logic                                      rst,
  input  logic [T_DATA_WIDTH-1:0]                   s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                   s_qos_i,
  input  logic [T_ID___WIDTH-1:0]                   s_id_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] m_qos_o,
  output logic [STREAM_COUNT-1:0]                   m_last_o,
  output logic [STREAM_COUNT-1:0]                   m_valid_o,
  input  logic [STREAM_COUNT-1:0]                   m_ready_i,
  output logic [DROP_CNT_W-1:0]                     drop_cnt_o
);

  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

  localparam logic [T_ID___WIDTH:0] ID_LIMIT = (T_ID___WIDTH+1)'(STREAM_COUNT);

  state_t                  state_q;
  logic                    out_valid_q;
  logic [T_ID___WIDTH-1:0] out_sel_q;
  logic [T_ID___WIDTH-1:0] route_q;
  logic [T_DATA_WIDTH-1:0] data_q;
  logic [T_QOS__WIDTH-1:0] qos_q;
  logic                    last_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;

  logic                    id_ok;
  logic                    free;
  logic                    accept;
  logic                    load;
  logic                    drop_head;
  logic [T_ID___WIDTH-1:0] sel_d;

  assign id_ok  = ({1'b0, s_id_i} < ID_LIMIT);
  // Only the selected port's ready can free the register; the others are don't-care.
  assign free   = !out_valid_q || m_ready_i[out_sel_q];

  always_comb begin
    s_ready_o = free;
    if (state_q == DROP || (state_q == HEAD && !id_ok)) begin
      s_ready_o = 1'b1;
    end
  end

  assign accept    = s_valid_i && s_ready_o;
  assign load      = accept && ((state_q == HEAD && id_ok) || state_q == BODY);
  assign drop_head = accept && state_q == HEAD && !id_ok;
  assign sel_d     = (state_q == HEAD) ? s_id_i : route_q;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q     <= HEAD;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      route_q     <= '0;
      data_q      <= '0;
      qos_q       <= '0;
      last_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_sel_q   <= sel_d;
        data_q      <= s_data_i;
        qos_q       <= s_qos_i;
        last_q      <= s_last_i;
      end else if (free) begin
        out_valid_q <= 1'b0;
      end

      if (drop_head && drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end

      if (accept) begin
        case (state_q)
          HEAD: begin
            route_q <= s_id_i;
            if (!s_last_i) begin
              state_q <= id_ok ? BODY : DROP;
            end
          end
          BODY, DROP: begin
            if (s_last_i) begin
              state_q <= HEAD;
            end
          end
          default: state_q <= HEAD;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < STREAM_COUNT; i++) begin
      m_data_o[i]  = data_q;
      m_qos_o[i]   = qos_q;
      m_last_o[i]  = last_q;
      m_valid_o[i] = out_valid_q && (out_sel_q == T_ID___WIDTH'(i));
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// tb/tb_stream_demux_router.sv - scoreboard bench for stream_demux_router (3 ports, 4-bit drop counter)
module tb_stream_demux_router;

  localparam int DW = 8;
  localparam int QW = 4;
  localparam int SC = 3;
  localparam int IW = 2;
  localparam int CW = 4;

  logic                    clk_i = 1'b0;
  logic                    rst;
  logic [DW-1:0]           s_data_i;
  logic [QW-1:0]           s_qos_i;
  logic [IW-1:0]           s_id_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [SC-1:0][DW-1:0]   m_data_o;
  logic [SC-1:0][QW-1:0]   m_qos_o;
  logic [SC-1:0]           m_last_o;
  logic [SC-1:0]           m_valid_o;
  logic [SC-1:0]           m_ready_i;
  logic [CW-1:0]           drop_cnt_o;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
    logic [QW-1:0] qos;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  stream_demux_router #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC),
    .T_ID___WIDTH(IW), .DROP_CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .rst(rst),
    .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_id_i(s_id_i),
    .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one beat, waits for acceptance and pushes the expected output (port < 0: dropped beat).
  task automatic send(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [QW-1:0] q,
                      input logic l, input int port);
    bit   done;
    exp_t e;
    done = 0;
    s_id_i = id; s_data_i = d; s_qos_i = q; s_last_i = l; s_valid_i = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        if (port >= 0) begin
          e.port = port[1:0]; e.data = d; e.qos = q; e.last = l;
          sb.push_back(e);
        end
        done = 1;
      end
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout data=0x%0h never accepted", d);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst) begin
      checks++;
      if ($countones(m_valid_o) > 1) begin
        failures++;
        $display("FAIL onehot m_valid_o=%b", m_valid_o);
      end
      for (int i = 0; i < SC; i++) begin
        if (m_valid_o[i] && m_ready_i[i]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected port=%0d data=0x%0h expected=none", i, m_data_o[i]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.port != 2'(i) || e.data != m_data_o[i] || e.qos != m_qos_o[i] || e.last != m_last_o[i]) begin
              failures++;
              $display("FAIL sb_beat actual port=%0d data=0x%0h qos=%0h last=%0b expected port=%0d data=0x%0h qos=%0h last=%0b",
                       i, m_data_o[i], m_qos_o[i], m_last_o[i], e.port, e.data, e.qos, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; s_valid_i = 1'b0; s_data_i = '0; s_qos_i = '0; s_id_i = '0; s_last_i = 1'b0;
    m_ready_i = 3'b111;
    #3;
    // T1 reset
    chk("t1_valid_in_reset", 32'(m_valid_o), 32'h0);
    chk("t1_drop_in_reset", 32'(drop_cnt_o), 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst = 1'b0;
    #1;
    chk("t1_ready_after", 32'(s_ready_o), 32'h1);

    // T2 3-beat packet to port 2
    send(2'd2, 8'hA1, 4'h1, 1'b0, 2);
    chk("t2_valid_b1", 32'(m_valid_o), 32'b100);
    send(2'd0, 8'hA2, 4'h2, 1'b0, 2);
    chk("t2_valid_b2", 32'(m_valid_o), 32'b100);
    send(2'd1, 8'hA3, 4'h3, 1'b1, 2);
    chk("t2_valid_b3", 32'(m_valid_o), 32'b100);
    chk("t2_last_b3", 32'(m_last_o[2]), 32'h1);

    // T3 id only sampled on header
    send(2'd0, 8'hC1, 4'h4, 1'b0, 0);
    chk("t3_valid_b1", 32'(m_valid_o), 32'b001);
    send(2'd1, 8'hC2, 4'h5, 1'b0, 0);
    chk("t3_valid_b2", 32'(m_valid_o), 32'b001);
    send(2'd1, 8'hC3, 4'h6, 1'b1, 0);
    chk("t3_valid_b3", 32'(m_valid_o), 32'b001);

    // T4 backpressure on port 1
    m_ready_i = 3'b101;
    send(2'd1, 8'hB1, 4'h7, 1'b0, 1);
    s_id_i = 2'd1; s_data_i = 8'hB2; s_qos_i = 4'h8; s_last_i = 1'b0; s_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t4_stall_ready", 32'(s_ready_o), 32'h0);
      chk("t4_hold_data", 32'(m_data_o[1]), 32'hB1);
      chk("t4_hold_valid", 32'(m_valid_o), 32'b010);
    end
    @(posedge clk_i); #1;
    m_ready_i = 3'b111;
    send(2'd1, 8'hB2, 4'h8, 1'b0, 1);
    chk("t4_next_data", 32'(m_data_o[1]), 32'hB2);
    send(2'd1, 8'hB3, 4'h9, 1'b1, 1);

    // T5 out-of-range id dropped, counter saturates
    send(2'd3, 8'hD1, 4'hA, 1'b0, -1);
    chk("t5_drop_valid", 32'(m_valid_o), 32'h0);
    send(2'd0, 8'hD2, 4'hB, 1'b1, -1);
    chk("t5_drop_valid2", 32'(m_valid_o), 32'h0);
    chk("t5_drop_cnt", 32'(drop_cnt_o), 32'h1);
    send(2'd1, 8'hE1, 4'hC, 1'b0, 1);
    chk("t5_route_after", 32'(m_valid_o), 32'b010);
    send(2'd2, 8'hE2, 4'hD, 1'b1, 1);
    for (int k = 0; k < 14; k++) send(2'd3, 8'(k), 4'h0, 1'b1, -1);
    chk("t5_cnt_full", 32'(drop_cnt_o), 32'hF);
    send(2'd3, 8'hFF, 4'h0, 1'b1, -1);
    chk("t5_cnt_sat", 32'(drop_cnt_o), 32'hF);

    // T6 reset mid-packet
    send(2'd1, 8'h61, 4'h1, 1'b0, 1);
    send(2'd0, 8'h62, 4'h2, 1'b0, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_valid_clr", 32'(m_valid_o), 32'h0);
    chk("t6_cnt_clr", 32'(drop_cnt_o), 32'h0);
    @(posedge clk_i); #2;
    rst = 1'b0;
    #1;
    send(2'd0, 8'h63, 4'h3, 1'b1, 0);
    chk("t6_new_header", 32'(m_valid_o), 32'b001);

    repeat (4) @(posedge clk_i);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
